// File: rtl/qspi_pkg.sv
// Shared definitions for the quad-SPI RAM responder: protocol states and command opcodes.
package qspi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_READ,
    ST_WRITE,
    ST_IGNORE
  } qspi_state_e;

  localparam logic [7:0]  CMD_QREAD    = 8'hEB;
  localparam logic [7:0]  CMD_QWRITE   = 8'h38;
  localparam logic [3:0]  ADDR_LAST    = 4'd5;   // six address nibbles, counted 0..5

endpackage

// File: rtl/qspi_ram_responder_if.sv
// Quad-SPI pins plus the byte-wide backing-store port of the responder.
interface qspi_ram_responder_if #(
  parameter int unsigned ADDR_BITS = 24
);

  logic                 spi_clk;
  logic                 spi_cs_n;
  logic [3:0]           spi_data_in;
  logic [3:0]           spi_data_out;
  logic [3:0]           spi_data_oe;
  logic [ADDR_BITS-1:0] mem_addr;
  logic                 mem_rd;
  logic [7:0]           mem_rdata;
  logic                 mem_wr;
  logic [7:0]           mem_wdata;

  modport slave (
    input  spi_clk, spi_cs_n, spi_data_in, mem_rdata,
    output spi_data_out, spi_data_oe, mem_addr, mem_rd, mem_wr, mem_wdata
  );

  modport master (
    output spi_clk, spi_cs_n, spi_data_in, mem_rdata,
    input  spi_data_out, spi_data_oe, mem_addr, mem_rd, mem_wr, mem_wdata
  );

endinterface

// File: rtl/qspi_edge_detect.sv
// Registers the initiator's spi_clk and flags single-cycle rise/fall strobes.
module qspi_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic spi_clk_i,
  output logic rise_o,
  output logic fall_o
);

  logic spi_clk_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) spi_clk_q <= 1'b0;
    else     spi_clk_q <= spi_clk_i;
  end

  assign rise_o = spi_clk_i & ~spi_clk_q;
  assign fall_o = ~spi_clk_i & spi_clk_q;

endmodule

// File: rtl/qspi_ram_responder.sv
// Quad-SPI RAM slave: 0xEB quad read with dummy clocks and prefetch, 0x38 quad write.
module qspi_ram_responder
  import qspi_pkg::*;
#(
  parameter int unsigned ADDR_BITS    = 24,
  parameter int unsigned DUMMY_CYCLES = 6
) (
  input logic                 clk,
  input logic                 rst,
  qspi_ram_responder_if.slave bus
);

  logic rise, fall;

  qspi_edge_detect u_edge (
    .clk       (clk),
    .rst       (rst),
    .spi_clk_i (bus.spi_clk),
    .rise_o    (rise),
    .fall_o    (fall)
  );

  qspi_state_e          state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [3:0]           cmd_hi_q, cmd_hi_d;
  logic                 wr_mode_q, wr_mode_d;
  logic [19:0]          sh_q, sh_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [3:0]           nib_q, nib_d;
  logic [7:0]           byte_q, byte_d;
  logic                 rd_pend_q, rd_pend_d;
  logic                 cs_n_q;
  logic [3:0]           out_q, out_d;
  logic                 oe_q, oe_d;
  logic                 rd_q, rd_d;
  logic                 wr_q, wr_d;
  logic [7:0]           wdata_q, wdata_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_hi_d  = cmd_hi_q;
    wr_mode_d = wr_mode_q;
    sh_d      = sh_q;
    addr_d    = addr_q;
    nib_d     = nib_q;
    byte_d    = byte_q;
    rd_pend_d = rd_q;
    out_d     = out_q;
    oe_d      = oe_q;
    rd_d      = 1'b0;
    wr_d      = 1'b0;
    wdata_d   = wdata_q;

    if (rd_pend_q) byte_d = bus.mem_rdata;
    // Post-write increment lands the cycle after mem_wr so the strobe sees the old address.
    if (wr_q) addr_d = addr_q + ADDR_BITS'(1);

    if (bus.spi_cs_n) begin
      state_d = ST_IDLE;
      oe_d    = 1'b0;
      out_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cs_n_q) begin
            state_d = ST_CMD;
            cnt_d   = '0;
          end
        end
        ST_CMD: begin
          if (rise) begin
            cmd_hi_d = bus.spi_data_in;
            cnt_d    = cnt_q + 4'd1;
            if (cnt_q != 4'd0) begin
              cnt_d = '0;
              unique case ({cmd_hi_q, bus.spi_data_in})
                CMD_QREAD:  begin state_d = ST_ADDR; wr_mode_d = 1'b0; end
                CMD_QWRITE: begin state_d = ST_ADDR; wr_mode_d = 1'b1; end
                default:    state_d = ST_IGNORE;
              endcase
            end
          end
        end
        ST_ADDR: begin
          if (rise) begin
            sh_d  = {sh_q[15:0], bus.spi_data_in};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == ADDR_LAST) begin
              addr_d = ADDR_BITS'({sh_q, bus.spi_data_in});
              cnt_d  = '0;
              if (wr_mode_q) begin
                state_d = ST_WRITE;
              end else begin
                rd_d    = 1'b1;
                state_d = ST_DUMMY;
              end
            end
          end
        end
        ST_DUMMY: begin
          if (rise) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'(DUMMY_CYCLES - 1)) begin
              cnt_d   = '0;
              state_d = ST_READ;
            end
          end
        end
        ST_READ: begin
          if (fall) begin
            cnt_d = {cnt_q[3:1], ~cnt_q[0]};
            if (!cnt_q[0]) begin
              // Low nibble is parked so the prefetch may overwrite byte_q meanwhile.
              out_d  = byte_q[7:4];
              nib_d  = byte_q[3:0];
              oe_d   = 1'b1;
              rd_d   = 1'b1;
              addr_d = addr_q + ADDR_BITS'(1);
            end else begin
              out_d = nib_q;
            end
          end
        end
        ST_WRITE: begin
          if (rise) begin
            cnt_d = {cnt_q[3:1], ~cnt_q[0]};
            if (!cnt_q[0]) begin
              nib_d = bus.spi_data_in;
            end else begin
              wr_d    = 1'b1;
              wdata_d = {nib_q, bus.spi_data_in};
            end
          end
        end
        ST_IGNORE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cmd_hi_q  <= '0;
      wr_mode_q <= 1'b0;
      sh_q      <= '0;
      addr_q    <= '0;
      nib_q     <= '0;
      byte_q    <= '0;
      rd_pend_q <= 1'b0;
      cs_n_q    <= 1'b0;
      out_q     <= '0;
      oe_q      <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_hi_q  <= cmd_hi_d;
      wr_mode_q <= wr_mode_d;
      sh_q      <= sh_d;
      addr_q    <= addr_d;
      nib_q     <= nib_d;
      byte_q    <= byte_d;
      rd_pend_q <= rd_pend_d;
      cs_n_q    <= bus.spi_cs_n;
      out_q     <= out_d;
      oe_q      <= oe_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign bus.spi_data_out = out_q;
  assign bus.spi_data_oe  = {4{oe_q}};
  assign bus.mem_addr     = addr_q;
  assign bus.mem_rd       = rd_q;
  assign bus.mem_wr       = wr_q;
  assign bus.mem_wdata    = wdata_q;

endmodule

// File: tb/tb_qspi_ram_responder.sv
// Randomized quad-SPI initiator with a transaction-level memory/bus model and per-cycle checker.
module tb_qspi_ram_responder;

  localparam int unsigned AB   = 24;
  localparam int unsigned DC   = 6;
  localparam int unsigned MASK = (32'd1 << AB) - 32'd1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  qspi_ram_responder_if #(.ADDR_BITS(AB)) bus ();

  qspi_ram_responder #(.ADDR_BITS(AB), .DUMMY_CYCLES(DC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model memory: written bytes override a deterministic per-address fill pattern.
  logic [7:0] ref_mem [int unsigned];

  function automatic logic [7:0] fill(input int unsigned a);
    return 8'(a * 37 + (a >> 8) * 11 + 91);
  endfunction

  function automatic logic [7:0] ref_get(input int unsigned a);
    return ref_mem.exists(a) ? ref_mem[a] : fill(a);
  endfunction

  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_rdata <= ref_get(32'(bus.mem_addr));
  end

  int unsigned exp_rd[$];
  int unsigned exp_wr_a[$];
  logic [7:0]  exp_wr_d[$];
  int unsigned rd_log[$];
  int unsigned wr_log_a[$];
  logic [7:0]  wr_log_d[$];
  logic [3:0]  obs[$];
  logic [7:0]  wdat[$];
  bit          exp_oe  = 1'b0;
  logic [3:0]  exp_out = '0;

  always @(negedge clk) begin
    if (!rst) begin
      chk("rd_wr_exclusive", 32'(bus.mem_rd & bus.mem_wr), 32'd0);
      chk("oe", 32'(bus.spi_data_oe), exp_oe ? 32'hF : 32'h0);
      if (exp_oe) chk("data_out", 32'(bus.spi_data_out), 32'(exp_out));
      if (bus.mem_rd) begin
        rd_log.push_back(32'(bus.mem_addr));
        chk("rd_expected", 32'(exp_rd.size() != 0), 32'd1);
        if (exp_rd.size() != 0) chk("rd_addr", 32'(bus.mem_addr), exp_rd.pop_front());
      end
      if (bus.mem_wr) begin
        wr_log_a.push_back(32'(bus.mem_addr));
        wr_log_d.push_back(bus.mem_wdata);
        chk("wr_expected", 32'(exp_wr_a.size() != 0), 32'd1);
        if (exp_wr_a.size() != 0) begin
          chk("wr_addr", 32'(bus.mem_addr), exp_wr_a.pop_front());
          chk("wr_data", 32'(bus.mem_wdata), 32'(exp_wr_d.pop_front()));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold();
    repeat ($urandom_range(2, 0)) tick();
  endtask

  task automatic rise(input logic [3:0] n);
    bus.spi_data_in = n;
    bus.spi_clk     = 1'b1;
    tick();
    hold();
  endtask

  task automatic fall();
    bus.spi_clk = 1'b0;
    tick();
    hold();
  endtask

  task automatic fall_drv(input logic [3:0] n);
    bus.spi_clk = 1'b0;
    tick();
    exp_oe  = 1'b1;
    exp_out = n;
    hold();
  endtask

  task automatic start_cs();
    bus.spi_cs_n = 1'b0;
    tick();
    tick();
  endtask

  task automatic end_cs();
    bus.spi_cs_n = 1'b1;
    tick();
    exp_oe      = 1'b0;
    bus.spi_clk = 1'b0;
    tick();
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rise(b[7:4]); fall();
    rise(b[3:0]); fall();
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input int unsigned addr);
    logic [23:0] a24;
    a24 = addr[23:0];
    start_cs();
    send_byte(cmd);
    for (int i = 0; i < 6; i++) begin
      if (i == 5 && cmd == 8'hEB) exp_rd.push_back(addr & MASK);
      rise(a24[23 - 4*i -: 4]);
      fall();
    end
  endtask

  task automatic do_read(input int unsigned addr, input int unsigned nnib);
    logic [7:0] b;
    send_hdr(8'hEB, addr);
    for (int d = 0; d < int'(DC); d++) begin
      rise(4'($urandom));
      if (d < int'(DC) - 1) fall();
    end
    for (int i = 0; i < int'(nnib); i++) begin
      b = ref_get((addr + 32'(i / 2)) & MASK);
      if (i % 2 == 0) exp_rd.push_back((addr + 32'(i / 2) + 1) & MASK);
      fall_drv((i % 2 == 0) ? b[7:4] : b[3:0]);
      obs.push_back(bus.spi_data_out);
      rise(4'($urandom));
    end
    end_cs();
  endtask

  task automatic do_write(input int unsigned addr, input bit abort_tail);
    int unsigned a;
    a = addr & MASK;
    send_hdr(8'h38, addr);
    foreach (wdat[i]) begin
      rise(wdat[i][7:4]); fall();
      exp_wr_a.push_back(a);
      exp_wr_d.push_back(wdat[i]);
      ref_mem[a] = wdat[i];
      rise(wdat[i][3:0]); fall();
      a = (a + 1) & MASK;
    end
    if (abort_tail) begin
      rise(4'($urandom)); fall();
    end
    end_cs();
  endtask

  task automatic clear_logs();
    rd_log.delete(); wr_log_a.delete(); wr_log_d.delete(); obs.delete();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int unsigned kind, a;
    bus.spi_clk     = 1'b0;
    bus.spi_cs_n    = 1'b1;
    bus.spi_data_in = '0;
    bus.mem_rdata   = '0;
    ref_mem[32'h100] = 8'hA5;
    ref_mem[32'h101] = 8'h3C;

    #12;
    chk("reset_oe",    32'(bus.spi_data_oe),  32'h0);
    chk("reset_out",   32'(bus.spi_data_out), 32'h0);
    chk("reset_rd",    32'(bus.mem_rd),       32'h0);
    chk("reset_wr",    32'(bus.mem_wr),       32'h0);
    chk("reset_addr",  32'(bus.mem_addr),     32'h0);
    chk("reset_wdata", 32'(bus.mem_wdata),    32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) tick();

    // Quad read of two bytes at 0x100.
    clear_logs();
    do_read(32'h100, 4);
    chk("qread_nibbles", 32'(obs.size()), 32'd4);
    chk("qread_n0", 32'(obs[0]), 32'hA);
    chk("qread_n1", 32'(obs[1]), 32'h5);
    chk("qread_n2", 32'(obs[2]), 32'h3);
    chk("qread_n3", 32'(obs[3]), 32'hC);
    chk("qread_rd0", rd_log[0], 32'h100);
    chk("qread_rd1", rd_log[1], 32'h101);

    // Quad write 0x12 0x34 at 0x10.
    clear_logs();
    wdat = '{8'h12, 8'h34};
    do_write(32'h10, 1'b0);
    chk("qwrite_count", 32'(wr_log_a.size()), 32'd2);
    chk("qwrite_a0", wr_log_a[0], 32'h10);
    chk("qwrite_d0", 32'(wr_log_d[0]), 32'h12);
    chk("qwrite_a1", wr_log_a[1], 32'h11);
    chk("qwrite_d1", 32'(wr_log_d[1]), 32'h34);
    chk("qwrite_no_rd", 32'(rd_log.size()), 32'd0);

    // Address wrap at the top of the space.
    clear_logs();
    do_read(32'hFF_FFFF, 4);
    chk("wrap_rd0", rd_log[0], 32'hFF_FFFF);
    chk("wrap_rd1", rd_log[1], 32'h0);

    // Abort after one nibble, then chip-select rising together with the completing edge.
    clear_logs();
    wdat.delete();
    do_write(32'h200, 1'b1);
    send_hdr(8'h38, 32'h300);
    rise(4'h7); fall();
    bus.spi_data_in = 4'h9;
    bus.spi_clk     = 1'b1;
    bus.spi_cs_n    = 1'b1;
    tick();
    bus.spi_clk = 1'b0;
    repeat (3) tick();
    chk("abort_no_wr", 32'(wr_log_a.size()), 32'd0);
    do_read(32'h10, 3);

    // Unknown command is ignored until deselect.
    clear_logs();
    send_hdr(8'h9F, 32'h0);
    repeat (10) begin rise(4'($urandom)); fall(); end
    end_cs();
    chk("badcmd_no_rd", 32'(rd_log.size()), 32'd0);
    chk("badcmd_no_wr", 32'(wr_log_a.size()), 32'd0);

    // Reset in the middle of read data.
    send_hdr(8'hEB, 32'h40);
    for (int d = 0; d < int'(DC); d++) begin
      rise(4'h0);
      if (d < int'(DC) - 1) fall();
    end
    exp_rd.push_back(32'h41);
    fall_drv(ref_get(32'h40) >> 4);
    rise(4'h0);
    fall_drv(ref_get(32'h40) & 8'h0F);
    rise(4'h0);
    #3;
    rst    = 1'b1;
    exp_oe = 1'b0;
    #1;
    chk("rstmid_oe",    32'(bus.spi_data_oe),  32'h0);
    chk("rstmid_out",   32'(bus.spi_data_out), 32'h0);
    chk("rstmid_addr",  32'(bus.mem_addr),     32'h0);
    chk("rstmid_wdata", 32'(bus.mem_wdata),    32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      fall();
      chk("post_rst_addr", 32'(bus.mem_addr), 32'h0);
      rise(4'hB);
    end
    end_cs();
    do_read(32'h101, 2);

    // Randomized mix of reads, writes and aborted writes.
    for (int t = 0; t < 20; t++) begin
      kind = $urandom_range(2, 0);
      a    = ($urandom_range(3, 0) == 0) ? (MASK - 32'($urandom_range(1, 0))) : ($urandom & MASK);
      if (kind == 0) begin
        do_read(a, $urandom_range(6, 1));
      end else begin
        wdat.delete();
        repeat ($urandom_range(3, kind == 1 ? 1 : 0)) wdat.push_back(8'($urandom));
        do_write(a, kind == 2);
        if ($urandom_range(1, 0) == 1) do_read(a, 2 * wdat.size() + 1);
      end
    end

    repeat (3) tick();
    chk("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
    chk("wr_queue_drained", 32'(exp_wr_a.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/qspi_ram_responder.md
QSPI_RAM_RESPONDER -- requirements
Module: qspi_ram_responder

Interface
REQ-001 Parameters: ADDR_BITS, default 24, width of the memory byte address; DUMMY_CYCLES, default 6, quad dummy clocks before read data (legal 2..15).
REQ-002 clk  in  1  block clock; one clock domain only.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 spi_clk  in  1  QSPI clock from initiator, synchronous to clk, each level held for at least 1 clk cycle.
REQ-005 spi_cs_n  in  1  chip select, active low.
REQ-006 spi_data_in  in  4  quad data from initiator, bit 3 = IO3.
REQ-007 spi_data_out  out  4  quad data to initiator.
REQ-008 spi_data_oe  out  4  output enables, all bits equal, 1 = driving.
REQ-009 mem_addr  out  ADDR_BITS  byte address to backing store.
REQ-010 mem_rd  out  1  one-cycle read strobe; mem_rdata valid the following clk cycle.
REQ-011 mem_rdata  in  8  read byte.
REQ-012 mem_wr  out  1  one-cycle write strobe, qualified with mem_addr and mem_wdata.
REQ-013 mem_wdata  out  8  write byte.

Function
REQ-014 Edges: rise = spi_clk high while its previous registered value is low; fall = the converse; all protocol action occurs only on a detected edge while spi_cs_n is low.
REQ-015 States: IDLE, CMD, ADDR, DUMMY, READ, WRITE, IGNORE.
REQ-016 IDLE -> CMD on spi_cs_n low; the nibble counter clears.
REQ-017 CMD samples 2 nibbles on rises, MSB nibble first; 0xEB selects read, 0x38 selects write, and any other value goes to IGNORE.
REQ-018 ADDR samples 6 nibbles, MSB first, and keeps the low ADDR_BITS bits (24-bit field truncated).
REQ-019 Read: on the last address rise, pulse mem_rd with the received address, then enter DUMMY.
REQ-020 Write: after the last address nibble, enter WRITE directly; no dummy cycles.
REQ-021 DUMMY counts DUMMY_CYCLES rises, then enters READ; spi_data_oe stays 0 throughout DUMMY.
REQ-022 READ drive:
  - on the fall following the last dummy rise, set spi_data_oe=4'hF and drive the high nibble of the fetched byte;
  - on the next fall, drive the low nibble;
  - nibbles alternate thereafter, high nibble first.
REQ-023 READ prefetch: when a high nibble is driven, pulse mem_rd for address+1; the returned byte is latched and used for the next high nibble.
REQ-024 WRITE: nibbles are assembled high nibble first; on the rise sampling a low nibble, pulse mem_wr with the assembled byte and the current address, then increment the address.
REQ-025 Address increment wraps modulo 2^ADDR_BITS; no boundary stops.
REQ-026 IGNORE: outputs stay idle until spi_cs_n goes high.
REQ-027 spi_cs_n high in any state:
  - the next clk cycle returns to IDLE with spi_data_oe=0;
  - a partially assembled write byte is discarded;
  - no further mem_rd or mem_wr is issued.
REQ-028 spi_cs_n rising in the same cycle as a spi_clk edge: chip select wins and the edge is ignored.
REQ-029 mem_rd and mem_wr are never asserted in the same cycle.

Reset
REQ-030 On rst, in the same cycle (asynchronous): state=IDLE, spi_data_oe=0, spi_data_out=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0, all counters 0.
REQ-031 After rst deasserts, the first transaction starts only on a fresh spi_cs_n low; a reset asserted mid-transaction abandons it without any memory access.

Structure
REQ-032 Shared package qspi_pkg holds the state enum and the command constants CMD_QREAD=8'hEB and CMD_QWRITE=8'h38.
REQ-033 One sub-module, qspi_edge_detect, registers spi_clk and produces the rise and fall strobes; everything else is flat.

Verification
REQ-034 Quad read: send 0xEB, address 0x000100, with the memory model holding 0xA5 at 0x100 and 0x3C at 0x101, DUMMY_CYCLES=6, read 2 bytes -> nibbles A,5,3,C appear on the falls after the 6th dummy rise; oe=F only in READ.
REQ-035 Quad write: send 0x38, address 0x000010, data 0x12 0x34 -> mem_wr pulses twice: (0x10,0x12) then (0x11,0x34); no mem_rd.
REQ-036 Wrap: read at address 0xFFFFFF for 2 bytes -> mem_rd addresses are 0xFFFFFF then 0x000000.
REQ-037 Abort: raise spi_cs_n after 1 nibble of a write byte -> no mem_wr; the next 0xEB transaction behaves normally.
REQ-038 Bad command 0x9F followed by 10 clocks -> oe stays 0, no memory strobes; returns to IDLE on spi_cs_n high.
REQ-039 Reset mid-read -> oe drops in the same cycle; all outputs hold reset values until the next spi_cs_n low.
